// File: rtl/hawk_tbl_upd_wr.sv
// hawk_tbl_upd_wr: commits one table update (ATT entry, then TOL entry unless att_only) as single-beat AXI writes, then pulses done.
// Latency req->done 5 cycles att_only / 7 full with a zero-wait slave; AW/W held until accepted, B waited on (HAWK_TBL_WR_TMO_EN adds a TMO_CYC timeout).
module hawk_tbl_upd_wr #(
    parameter int                ADDR_W   = 64,
    parameter int                DATA_W   = 512,
    parameter int                LST_W    = 16,
    parameter logic [ADDR_W-1:0] ATT_BASE = ADDR_W'(64'hFFF6100000),
    parameter logic [ADDR_W-1:0] TOL_BASE = ADDR_W'(64'hFFF6200000),
    parameter int                TMO_CYC  = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tbl_update,
    input  logic                att_only,
    input  logic [LST_W-1:0]    att_entry_id,
    input  logic [1:0]          att_sts,
    input  logic [5:0]          att_zpd_cnt,
    input  logic [ADDR_W-13:0]  att_way,
    input  logic [LST_W-1:0]    tol_entry_id,
    input  logic [LST_W-1:0]    tol_next,
    output logic                ready,
    output logic                tbl_update_done,
    output logic                free_head_upd,
    output logic [LST_W-1:0]    free_head,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    output logic                wlast,
    input  logic                wready,
    input  logic                bvalid,
    input  logic [1:0]          bresp,
    output logic                bready,
    output logic                bus_error
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_HI = $clog2(STRB_W) - 1;

    typedef enum logic [2:0] {IDLE, ATT_WR, ATT_B, TOL_WR, TOL_B, DONE, ERR} state_t;
    state_t state, state_nxt;

    logic                att_only_q;
    logic [LST_W-1:0]    att_id_q, tol_id_q, tol_next_q;
    logic [1:0]          sts_q;
    logic [5:0]          zpd_q;
    logic [ADDR_W-13:0]  way_q;
    logic                aw_done, w_done;
    logic                aw_hs, w_hs, wr_st, b_st, tmo_hit;
    logic [ADDR_W-1:0]   att_addr, tol_addr;
    logic [63:0]         att_dat, tol_dat, wr_dat;
    logic [LANE_HI-3:0]  lane;

    // Entry ids are 1-based; id 0 is NULL and never requested.
    assign att_addr = ATT_BASE + ((ADDR_W'(att_id_q) - ADDR_W'(1)) << 3);
    assign tol_addr = TOL_BASE + ((ADDR_W'(tol_id_q) - ADDR_W'(1)) << 3);
    assign att_dat  = 64'({way_q, 4'b0, zpd_q, sts_q});
    // Popped TOL entry is detached: next and prev both NULL, owner = ATT entry.
    assign tol_dat  = 64'({att_id_q, {(2*LST_W){1'b0}}});

    assign awaddr  = (state == TOL_WR) ? tol_addr : att_addr;
    assign wr_dat  = (state == TOL_WR) ? tol_dat : att_dat;
    assign lane    = awaddr[LANE_HI:3];
    assign wdata   = DATA_W'(wr_dat) << {lane, 6'b0};
    assign wstrb   = STRB_W'(8'hFF) << {lane, 3'b0};
    assign wlast   = 1'b1;
    assign awlen   = 8'd0;
    assign awsize  = 3'd3;
    assign awburst = 2'b01;

    assign wr_st = (state == ATT_WR) || (state == TOL_WR);
    assign b_st  = (state == ATT_B) || (state == TOL_B);
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

`ifdef HAWK_TBL_WR_TMO_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = b_st && (tmo_cnt == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (state_nxt != state) begin
            tmo_cnt <= '0;
        end else if (b_st) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = TMO_CYC;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        bus_error = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (tbl_update) state_nxt = ATT_WR;
            end
            ATT_WR, TOL_WR: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs))
                    state_nxt = (state == ATT_WR) ? ATT_B : TOL_B;
            end
            ATT_B, TOL_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    if (bresp != 2'b00)       state_nxt = ERR;
                    else if (state == TOL_B)  state_nxt = DONE;
                    else                      state_nxt = att_only_q ? DONE : TOL_WR;
                end else if (tmo_hit) begin
                    state_nxt = ERR;
                end
            end
            DONE: state_nxt = IDLE;
            ERR:  bus_error = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags live only within one *_WR state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (wr_st && (state_nxt == state)) begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
        end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            att_only_q <= 1'b0;
            att_id_q   <= '0;
            tol_id_q   <= '0;
            tol_next_q <= '0;
            sts_q      <= '0;
            zpd_q      <= '0;
            way_q      <= '0;
        end else if (tbl_update && (state == IDLE)) begin
            att_only_q <= att_only;
            att_id_q   <= att_entry_id;
            tol_id_q   <= tol_entry_id;
            tol_next_q <= tol_next;
            sts_q      <= att_sts;
            zpd_q      <= att_zpd_cnt;
            way_q      <= att_way;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tbl_update_done <= 1'b0;
            free_head_upd   <= 1'b0;
            free_head       <= '0;
        end else begin
            tbl_update_done <= (state == DONE);
            free_head_upd   <= (state == DONE) && !att_only_q;
            if ((state == DONE) && !att_only_q) free_head <= tol_next_q;
        end
    end

endmodule

// File: tb/tb_hawk_tbl_upd_wr.sv
// Bench for hawk_tbl_upd_wr: scoreboard of expected AXI writes checked by a responder model, plus latency/flag checks.
module tb_hawk_tbl_upd_wr;

    localparam int TMO_CYC = 1024;
    localparam logic [63:0] ATT_B = 64'hFFF6100000;
    localparam logic [63:0] TOL_B = 64'hFFF6200000;

    typedef struct packed {
        logic [63:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
    } wr_t;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         tbl_update = 1'b0, att_only = 1'b0;
    logic [15:0]  att_entry_id = '0, tol_entry_id = '0, tol_next = '0;
    logic [1:0]   att_sts = '0;
    logic [5:0]   att_zpd_cnt = '0;
    logic [51:0]  att_way = '0;
    logic         ready, tbl_update_done, free_head_upd, bus_error;
    logic [15:0]  free_head;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid, awready, wvalid, wlast, wready, bready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         bvalid;
    logic [1:0]   bresp;

    int  n_checks = 0, n_errors = 0, done_cnt = 0;
    int  aw_stall_cfg = 0, stall_cnt;
    logic [1:0] resp_knob = 2'b00;
    bit  no_b = 1'b0;
    wr_t sb_q[$];

    hawk_tbl_upd_wr #(.TMO_CYC(TMO_CYC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .tbl_update(tbl_update), .att_only(att_only),
        .att_entry_id(att_entry_id), .att_sts(att_sts), .att_zpd_cnt(att_zpd_cnt), .att_way(att_way),
        .tol_entry_id(tol_entry_id), .tol_next(tol_next), .ready(ready),
        .tbl_update_done(tbl_update_done), .free_head_upd(free_head_upd), .free_head(free_head),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast),
        .wready(wready), .bvalid(bvalid), .bresp(bresp), .bready(bready), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic wr_t mk_wr(input logic [63:0] addr, input logic [63:0] d64);
        wr_t w;
        logic [511:0] d;
        logic [63:0] s;
        int off;
        off = int'(addr[5:3]);
        d = {448'b0, d64};
        s = 64'h00000000_000000FF;
        w.addr = addr;
        w.data = d << (64 * off);
        w.strb = s << (8 * off);
        return w;
    endfunction

    task automatic drive_req(input bit ao, input logic [15:0] id, input logic [1:0] sts,
                             input logic [5:0] zpd, input logic [51:0] way,
                             input logic [15:0] tid, input logic [15:0] tnext,
                             input bit push, input bit exp_tol);
        tbl_update = 1'b1; att_only = ao; att_entry_id = id; att_sts = sts;
        att_zpd_cnt = zpd; att_way = way; tol_entry_id = tid; tol_next = tnext;
        if (push) begin
            sb_q.push_back(mk_wr(ATT_B + 64'(id - 16'd1) * 8, {way, 4'b0, zpd, sts}));
            if (!ao && exp_tol)
                sb_q.push_back(mk_wr(TOL_B + 64'(tid - 16'd1) * 8, {32'b0, id, 16'h0, 16'h0}));
        end
    endtask

    task automatic wait_done(output int cyc, output bit hit);
        cyc = 1;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk); #1;
            tbl_update = 1'b0;
            cyc++;
            if (tbl_update_done) hit = 1'b1;
        end
        if (!hit) chk("done_timeout", 0, 1);
    endtask

    // Responder: AW/W captured independently, B issued the cycle after both arrive.
    assign wready  = 1'b1;
    assign awready = (stall_cnt >= aw_stall_cfg);
    wire aw_hs = awvalid && awready;
    wire w_hs  = wvalid && wready;
    logic aw_got, w_got;
    wr_t  got_q, cur;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00; stall_cnt <= 0;
        end else begin
            if (bvalid && bready) bvalid <= 1'b0;
            if (awvalid && !awready) stall_cnt <= stall_cnt + 1;
            if (aw_hs) begin
                stall_cnt <= 0;
                aw_got <= 1'b1;
                got_q.addr <= awaddr;
                chk("aw_attr", {awlen, awsize, awburst}, {8'd0, 3'd3, 2'b01});
            end
            if (w_hs) begin
                w_got <= 1'b1;
                got_q.data <= wdata;
                got_q.strb <= wstrb;
                chk("wlast", wlast, 1);
            end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                cur.addr = aw_hs ? awaddr : got_q.addr;
                cur.data = w_hs ? wdata : got_q.data;
                cur.strb = w_hs ? wstrb : got_q.strb;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_wr", cur.addr, 0);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    chk("wr_addr", cur.addr, e.addr);
                    chk("wr_data", cur.data, e.data);
                    chk("wr_strb", cur.strb, e.strb);
                end
                if (!no_b) begin
                    bvalid <= 1'b1;
                    bresp  <= resp_knob;
                end
            end
        end
    end

    always @(negedge clk) if (rst_n && tbl_update_done) done_cnt++;

    always @(negedge clk)
        if (rst_n && tbl_update && ready)
            assert (att_entry_id != 16'd0) else $error("att_entry_id of 0 requested");

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc;
        bit  hit;
        int  exp_done;
        wr_t lit;
        exp_done = 0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_ready", ready, 1);
        chk("rst_valids", {awvalid, wvalid, bready}, 3'b000);
        chk("rst_pulses", {tbl_update_done, free_head_upd}, 2'b00);
        chk("rst_free_head", free_head, 0);
        chk("rst_bus_error", bus_error, 0);
        @(posedge clk); #1;

        // ATT-only update with hand-derived expected beat
        drive_req(1'b1, 16'd5, 2'd1, 6'd3, 52'h80123, 16'd0, 16'd0, 1'b0, 1'b0);
        lit.addr = 64'h000000FF_F6100020;
        lit.data = 512'h8012300D << 256;
        lit.strb = 64'h000000FF_00000000;
        sb_q.push_back(lit);
        wait_done(cyc, hit);
        chk("t1_latency", cyc, 5);
        chk("t1_no_fhu", free_head_upd, 0);
        exp_done++;
        repeat (2) @(posedge clk); #1;
        chk("t1_ready", ready, 1);
        chk("t1_done_cnt", done_cnt, exp_done);

        // Full update: ATT then TOL, free head published with done
        drive_req(1'b0, 16'd1, 2'd2, 6'd63, 52'hABCDE, 16'd2, 16'd3, 1'b1, 1'b1);
        wait_done(cyc, hit);
        chk("t2_latency", cyc, 7);
        chk("t2_fhu", free_head_upd, 1);
        chk("t2_free_head", free_head, 3);
        exp_done++;
        @(posedge clk); #1;
        chk("t2_fhu_pulse", free_head_upd, 0);

        // AW stalled 4 cycles, W accepted at once
        aw_stall_cfg = 4;
        drive_req(1'b1, 16'd14, 2'd3, 6'd10, 52'h5, 16'd0, 16'd0, 1'b1, 1'b0);
        @(posedge clk); #1;
        tbl_update = 1'b0;
        chk("t3_both_valid", {awvalid, wvalid}, 2'b11);
        @(posedge clk); #1;
        chk("t3_w_dropped", {awvalid, wvalid}, 2'b10);
        wait_done(cyc, hit);
        chk("t3_done", hit, 1);
        exp_done++;
        aw_stall_cfg = 0;

        // Second strobe while busy is ignored
        drive_req(1'b0, 16'd7, 2'd0, 6'd1, 52'hFFFFF, 16'd4, 16'd11, 1'b1, 1'b1);
        @(posedge clk); #1;
        tbl_update = 1'b0;
        @(posedge clk); #1;
        drive_req(1'b1, 16'd9, 2'd1, 6'd2, 52'h1, 16'd8, 16'd9, 1'b0, 1'b0);
        wait_done(cyc, hit);
        chk("t4_free_head", free_head, 11);
        exp_done++;
        repeat (10) @(posedge clk); #1;
        chk("t4_done_cnt", done_cnt, exp_done);
        chk("t4_ready", ready, 1);

        // Error response on ATT write: no TOL write, no done, sticky until reset
        resp_knob = 2'b10;
        drive_req(1'b0, 16'd3, 2'd1, 6'd4, 52'h77, 16'd5, 16'd6, 1'b1, 1'b0);
        @(posedge clk); #1;
        tbl_update = 1'b0;
        repeat (20) @(posedge clk); #1;
        chk("t5_bus_error", bus_error, 1);
        chk("t5_not_ready", ready, 0);
        chk("t5_done_cnt", done_cnt, exp_done);
        chk("t5_sb_empty", sb_q.size(), 0);
        resp_knob = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_bus_error", bus_error, 0);
        chk("t5_rst_ready", ready, 1);
        chk("t5_rst_free_head", free_head, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef HAWK_TBL_WR_TMO_EN
        // No B response: error exactly TMO_CYC cycles after entering ATT_B
        no_b = 1'b1;
        drive_req(1'b0, 16'd2, 2'd0, 6'd0, 52'h3, 16'd4, 16'd5, 1'b1, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk); #1;
            tbl_update = 1'b0;
            if (bready) hit = 1'b1;
        end
        chk("t6_reach_b", hit, 1);
        cyc = 0;
        hit = 1'b0;
        for (int i = 0; i < TMO_CYC + 50 && !hit; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus_error) hit = 1'b1;
        end
        chk("t6_tmo_cycles", cyc, TMO_CYC);
        no_b = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_bus_error", bus_error, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
`endif

        repeat (3) @(posedge clk); #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
